// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder built on a single full-adder cell with a
// registered carry. Operands are captured on start, one bit is processed per
// clock (LSB first), and the result is published in the cycle done pulses.
// Optional subtract mode is enabled by defining SERIAL_ADDER_SUB_EN, which
// adds a 'sub' input port.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    // Counter must be at least one bit wide so WIDTH=1 still builds.
    localparam int             CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] s_sr_q, s_sr_d;
    logic             c_q, c_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;

    logic             fa_s, fa_c;
    logic [WIDTH:0]   s_ext;
    logic [WIDTH-1:0] b_ld;
    logic             c_ld;

    // Operand B and initial carry as loaded; subtract forms a + ~b + 1.
`ifdef SERIAL_ADDER_SUB_EN
    assign b_ld = sub ? ~b : b;
    assign c_ld = sub ? 1'b1 : cin;
`else
    assign b_ld = b;
    assign c_ld = cin;
`endif

    // The single full-adder cell shared by every bit position.
    assign fa_s  = a_sr_q[0] ^ b_sr_q[0] ^ c_q;
    assign fa_c  = (a_sr_q[0] & b_sr_q[0]) | (a_sr_q[0] & c_q) | (b_sr_q[0] & c_q);
    // New sum bit enters at the MSB; slicing the extended vector avoids a
    // zero-width part-select when WIDTH=1.
    assign s_ext = {fa_s, s_sr_q};

    // Next-state and datapath sequencing.
    always_comb begin
        state_d = state_q;
        a_sr_d  = a_sr_q;
        b_sr_d  = b_sr_q;
        s_sr_d  = s_sr_q;
        c_d     = c_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_sr_d  = a;
                    b_sr_d  = b_ld;
                    c_d     = c_ld;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_sr_d = a_sr_q >> 1;
                b_sr_d = b_sr_q >> 1;
                s_sr_d = s_ext[WIDTH:1];
                c_d    = fa_c;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    // Publish on the last bit so outputs never show partials.
                    sum_d   = s_ext[WIDTH:1];
                    cout_d  = fa_c;
                    state_d = DONE;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            s_sr_q  <= '0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sr_q  <= a_sr_d;
            b_sr_q  <= b_sr_d;
            s_sr_q  <= s_sr_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: a WIDTH=1 and a WIDTH=8 instance, directed vectors
// with hand-computed results queued into per-instance scoreboards that a
// monitor drains on every done pulse.
module tb_serial_adder;

    typedef struct {
        logic [7:0] s;
        logic       c;
        int         cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start1 = 1'b0, start8 = 1'b0;
    logic [0:0] a1 = '0, b1 = '0;
    logic       cin1 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       cin8 = 1'b0;
    logic       sub8 = 1'b0;
    logic       busy1, done1, cout1, busy8, done8, cout8;
    logic [0:0] sum1;
    logic [7:0] sum8;

    int   n = 0;            // posedges seen so far
    logic rst_edge = 1'b1;  // rst value at the most recent posedge
    int   vec = 0, miss = 0;
    exp_t q1[$], q8[$];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        n        <= n + 1;
        rst_edge <= rst;
    end

    serial_adder #(.WIDTH(1)) u1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(1'b0),
`endif
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
    );

    serial_adder #(.WIDTH(8)) u8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(sub8),
`endif
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );

    // Monitor: pops an expectation on every done pulse, checks result,
    // latency and busy; also checks sum only moves on done or reset.
    logic [7:0] prev8;
    logic [0:0] prev1;
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done8) begin
                vec++;
                if (q8.size() == 0) begin
                    miss++;
                    $display("FAIL w8_unexpected_done cyc=%0d sum=%h cout=%b", n, sum8, cout8);
                end else begin
                    e = q8.pop_front();
                    if (sum8 !== e.s || cout8 !== e.c || n != e.cyc || busy8 !== 1'b0) begin
                        miss++;
                        $display("FAIL w8_result got sum=%h cout=%b cyc=%0d busy=%b, want sum=%h cout=%b cyc=%0d busy=0",
                                 sum8, cout8, n, busy8, e.s, e.c, e.cyc);
                    end
                end
            end
            if (done1) begin
                vec++;
                if (q1.size() == 0) begin
                    miss++;
                    $display("FAIL w1_unexpected_done cyc=%0d sum=%b cout=%b", n, sum1, cout1);
                end else begin
                    e = q1.pop_front();
                    if (sum1 !== e.s[0] || cout1 !== e.c || n != e.cyc || busy1 !== 1'b0) begin
                        miss++;
                        $display("FAIL w1_result got sum=%b cout=%b cyc=%0d busy=%b, want sum=%b cout=%b cyc=%0d busy=0",
                                 sum1, cout1, n, busy1, e.s[0], e.c, e.cyc);
                    end
                end
            end
            if (!rst_edge && !done8 && sum8 !== prev8) begin
                vec++; miss++;
                $display("FAIL w8_sum_stable got %h want %h", sum8, prev8);
            end
            if (!rst_edge && !done1 && sum1 !== prev1) begin
                vec++; miss++;
                $display("FAIL w1_sum_stable got %b want %b", sum1, prev1);
            end
            prev8 = sum8;
            prev1 = sum1;
        end
    end

    task automatic wait_done(input bit w8);
        bit seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (w8 ? done8 : done1) seen = 1'b1;
            else @(negedge clk);
        end
        if (!seen) begin
            vec++; miss++;
            $display("FAIL %s_timeout got no done want done", w8 ? "w8" : "w1");
        end
    endtask

    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic ci,
                        input logic sb, input logic [7:0] es, input logic ec);
        exp_t e;
        @(negedge clk);
        a8 = a; b8 = b; cin8 = ci; sub8 = sb; start8 = 1'b1;
        e.s = es; e.c = ec; e.cyc = n + 1 + 8;
        q8.push_back(e);
        @(negedge clk);
        start8 = 1'b0;
        wait_done(1'b1);
    endtask

    task automatic run1(input logic a, input logic b, input logic ci,
                        input logic es, input logic ec);
        exp_t e;
        @(negedge clk);
        a1 = a; b1 = b; cin1 = ci; start1 = 1'b1;
        e.s = {7'd0, es}; e.c = ec; e.cyc = n + 1 + 1;
        q1.push_back(e);
        @(negedge clk);
        start1 = 1'b0;
        wait_done(1'b0);
    endtask

    task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] want);
        vec++;
        if (got !== want) begin
            miss++;
            $display("FAIL %s got %h want %h", nm, got, want);
        end
    endtask

    // Full-adder truth table for {a,b,cin} = 0..7: {cout,sum}.
    logic [1:0] fa_tab [8] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

    initial begin
        int k;
        exp_t e;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy8", {7'd0, busy8}, 8'h00);
        chk("rst_done8", {7'd0, done8}, 8'h00);
        chk("rst_sum8",  sum8,          8'h00);
        chk("rst_cout8", {7'd0, cout8}, 8'h00);
        chk("rst_sum1",  {7'd0, sum1},  8'h00);
        chk("rst_busy1", {7'd0, busy1}, 8'h00);
        rst = 1'b0;

        // WIDTH=1 full-adder truth table
        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            logic [1:0] r;
            v = 3'(i);
            r = fa_tab[i];
            run1(v[2], v[1], v[0], r[0], r[1]);
        end

        // WIDTH=8 additions
        run8(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1);
        run8(8'hA5, 8'h5A, 1'b1, 1'b0, 8'h00, 1'b1);
        run8(8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0);

        // Start during RUN is ignored
        @(negedge clk);
        a8 = 8'h0F; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
        k = n + 1;
        e.s = 8'h10; e.c = 1'b0; e.cyc = k + 8;
        q8.push_back(e);
        @(negedge clk);
        start8 = 1'b0;
        repeat (2) @(negedge clk);
        a8 = 8'hFF; b8 = 8'hFF; start8 = 1'b1;   // hits edge k+3
        @(negedge clk);
        start8 = 1'b0;
        wait_done(1'b1);

        // Reset mid-operation aborts with no done
        @(negedge clk);
        a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;                              // hits edge k+4
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy8", {7'd0, busy8}, 8'h00);
        chk("abort_sum8",  sum8,          8'h00);
        chk("abort_cout8", {7'd0, cout8}, 8'h00);
        run8(8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1);

        // Start held high: one done every WIDTH+2 cycles
        @(negedge clk);
        a8 = 8'h01; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
        k = n + 1;
        for (int j = 0; j < 3; j++) begin
            e.s = 8'h02; e.c = 1'b0; e.cyc = k + 8 + 10 * j;
            q8.push_back(e);
        end
        repeat (28) @(negedge clk);
        start8 = 1'b0;
        repeat (4) @(negedge clk);

`ifdef SERIAL_ADDER_SUB_EN
        run8(8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0);
        run8(8'h07, 8'h05, 1'b0, 1'b1, 8'h02, 1'b1);
        run8(8'h07, 8'h05, 1'b0, 1'b0, 8'h0C, 1'b0);
`endif

        repeat (12) @(negedge clk);
        chk("q8_drained", 8'(q8.size()), 8'h00);
        chk("q1_drained", 8'(q1.size()), 8'h00);
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
